// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: owns the PC, requests instruction memory and fills IF/ID.
// A one-entry hold buffer keeps a returned instruction alive across hazard stalls.
module fetch_unit #(
  parameter int          N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         branchValid,
  input  logic         uncondBranch,
  input  logic         condBranch,
  input  logic [N-1:0] branchTarget,
  input  logic         stall,
  input  logic         imem_ready,
  input  logic [31:0]  imem_rdata,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  output logic [N-1:0] IF_ID_pc,
  output logic [31:0]  IF_ID_instr,
  output logic         IF_ID_valid,
  output logic         flush
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t       state;
  state_t       state_next;
  logic [N-1:0] pc;
  logic [N-1:0] buf_pc;
  logic [31:0]  buf_instr;
  logic         taken;
  logic         unused_target_lsbs;

  assign taken              = branchValid & (uncondBranch | condBranch);
  assign unused_target_lsbs = ^branchTarget[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (taken) begin
      state_next = FETCH;
    end else begin
      case (state)
        FETCH:   if (imem_ready && stall) state_next = HOLD;
        HOLD:    if (!stall)              state_next = FETCH;
        default: state_next = FETCH;
      endcase
    end
  end

  // imem_req is gated by reset so an in-flight request is abandoned immediately
  always_comb begin
    flush     = taken;
    imem_addr = pc;
    imem_req  = reset && (state == FETCH);
  end

  // A redirect overrides stall and drops any data returned in the same cycle;
  // the stale buffer contents are simply ignored once the state returns to FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      buf_pc      <= '0;
      buf_instr   <= '0;
      IF_ID_pc    <= '0;
      IF_ID_instr <= '0;
      IF_ID_valid <= 1'b0;
    end else if (taken) begin
      pc          <= {branchTarget[N-1:2], 2'b00};
      IF_ID_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            pc <= pc + N'(4);
            if (stall) begin
              buf_pc    <= pc;
              buf_instr <= imem_rdata;
            end else begin
              IF_ID_pc    <= pc;
              IF_ID_instr <= imem_rdata;
              IF_ID_valid <= 1'b1;
            end
          end else if (!stall) begin
            IF_ID_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            IF_ID_pc    <= buf_pc;
            IF_ID_instr <= buf_instr;
            IF_ID_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory returns 0x8B000000 + address.
module tb_fetch_unit;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         branchValid;
  logic         uncondBranch;
  logic         condBranch;
  logic [N-1:0] branchTarget;
  logic         stall;
  logic         imem_ready;
  logic [31:0]  imem_rdata;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic [N-1:0] IF_ID_pc;
  logic [31:0]  IF_ID_instr;
  logic         IF_ID_valid;
  logic         flush;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = 32'h8B00_0000 + imem_addr[31:0];

  fetch_unit #(.N(N), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset),
    .branchValid(branchValid), .uncondBranch(uncondBranch), .condBranch(condBranch),
    .branchTarget(branchTarget), .stall(stall),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .IF_ID_pc(IF_ID_pc), .IF_ID_instr(IF_ID_instr), .IF_ID_valid(IF_ID_valid),
    .flush(flush)
  );

  task automatic applyStimulus(input logic bv, input logic ub, input logic cb,
                               input logic [N-1:0] tgt, input logic st, input logic rdy);
    branchValid  = bv;
    uncondBranch = ub;
    condBranch   = cb;
    branchTarget = tgt;
    stall        = st;
    imem_ready   = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(0, 0, 0, '0, 0, 1);
    #3;
    checkOutput("rst_req",   imem_req,    0);
    checkOutput("rst_valid", IF_ID_valid, 0);
    checkOutput("rst_pc",    IF_ID_pc,    0);
    checkOutput("rst_instr", IF_ID_instr, 0);
    checkOutput("rst_addr",  imem_addr,   0);
    checkOutput("rst_flush", flush,       0);
    tick();
    tick();
    checkOutput("rst_hold_valid", IF_ID_valid, 0);
    reset = 1'b1;
    #1;
    checkOutput("rel_req", imem_req, 1);

    // sequential streaming
    tick();
    checkOutput("seq0_pc",    IF_ID_pc,    64'h0);
    checkOutput("seq0_valid", IF_ID_valid, 1);
    checkOutput("seq0_instr", IF_ID_instr, 32'h8B00_0000);
    tick();
    checkOutput("seq1_pc", IF_ID_pc, 64'h4);
    tick();
    checkOutput("seq2_pc", IF_ID_pc, 64'h8);
    tick();
    checkOutput("seq3_pc",    IF_ID_pc,    64'hC);
    checkOutput("seq3_instr", IF_ID_instr, 32'h8B00_000C);
    checkOutput("seq3_addr",  imem_addr,   64'h10);

    // taken B.cond
    applyStimulus(1, 0, 1, 64'h100, 0, 1);
    #1;
    checkOutput("bcond_flush", flush, 1);
    tick();
    applyStimulus(0, 0, 0, '0, 0, 1);
    #1;
    checkOutput("bcond_flush_t1", flush,       0);
    checkOutput("bcond_valid_t1", IF_ID_valid, 0);
    checkOutput("bcond_addr_t1",  imem_addr,   64'h100);
    tick();
    checkOutput("bcond_pc_t2",    IF_ID_pc,    64'h100);
    checkOutput("bcond_valid_t2", IF_ID_valid, 1);
    checkOutput("bcond_instr_t2", IF_ID_instr, 32'h8B00_0100);

    // not-taken branch in MEM
    applyStimulus(1, 0, 0, 64'h300, 0, 1);
    #1;
    checkOutput("nt_flush", flush, 0);
    tick();
    applyStimulus(0, 0, 0, '0, 0, 1);
    checkOutput("nt_pc",    IF_ID_pc,    64'h104);
    checkOutput("nt_valid", IF_ID_valid, 1);
    checkOutput("nt_addr",  imem_addr,   64'h108);

    // stall for 3 cycles with PC=0x20
    applyStimulus(1, 1, 0, 64'h1C, 0, 1);
    #1;
    checkOutput("b_flush", flush, 1);
    tick();
    applyStimulus(0, 0, 0, '0, 0, 1);
    tick();
    checkOutput("pre_stall_pc", IF_ID_pc,  64'h1C);
    checkOutput("pre_stall_addr", imem_addr, 64'h20);
    applyStimulus(0, 0, 0, '0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_pc",    IF_ID_pc,    64'h1C);
      checkOutput("stall_instr", IF_ID_instr, 32'h8B00_001C);
      checkOutput("stall_valid", IF_ID_valid, 1);
      checkOutput("stall_req",   imem_req,    0);
      checkOutput("stall_addr",  imem_addr,   64'h24);
    end
    applyStimulus(0, 0, 0, '0, 0, 1);
    tick();
    checkOutput("unstall_pc",    IF_ID_pc,    64'h20);
    checkOutput("unstall_instr", IF_ID_instr, 32'h8B00_0020);
    checkOutput("unstall_valid", IF_ID_valid, 1);
    checkOutput("unstall_req",   imem_req,    1);
    tick();
    checkOutput("unstall_next_pc", IF_ID_pc, 64'h24);

    // imem_ready low for 2 cycles at PC=0x40
    applyStimulus(1, 1, 0, 64'h40, 0, 1);
    tick();
    applyStimulus(0, 0, 0, '0, 0, 0);
    #1;
    checkOutput("wait_req", imem_req, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("wait_addr",  imem_addr,   64'h40);
      checkOutput("wait_valid", IF_ID_valid, 0);
      checkOutput("wait_req2",  imem_req,    1);
    end
    applyStimulus(0, 0, 0, '0, 0, 1);
    tick();
    checkOutput("ready_pc",    IF_ID_pc,    64'h40);
    checkOutput("ready_valid", IF_ID_valid, 1);
    tick();
    checkOutput("ready_next_pc", IF_ID_pc, 64'h44);

    // redirect while holding a buffered instruction
    applyStimulus(0, 0, 0, '0, 1, 1);
    tick();
    checkOutput("hold_req", imem_req, 0);
    checkOutput("hold_pc",  IF_ID_pc, 64'h44);
    applyStimulus(1, 1, 0, 64'h203, 1, 1);
    #1;
    checkOutput("hold_flush", flush, 1);
    tick();
    applyStimulus(0, 0, 0, '0, 0, 1);
    #1;
    checkOutput("redir_addr",  imem_addr,   64'h200);
    checkOutput("redir_valid", IF_ID_valid, 0);
    checkOutput("redir_req",   imem_req,    1);
    tick();
    checkOutput("redir_pc",    IF_ID_pc,    64'h200);
    checkOutput("redir_valid2", IF_ID_valid, 1);

    // PC wrap at top of address space
    applyStimulus(1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1);
    tick();
    applyStimulus(0, 0, 0, '0, 0, 1);
    checkOutput("wrap_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    checkOutput("wrap_pc",   IF_ID_pc,  64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap_addr", imem_addr, 64'h0);
    tick();
    checkOutput("wrap_next_pc", IF_ID_pc, 64'h0);

    // async reset in the middle of a waiting request
    applyStimulus(0, 0, 0, '0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_valid", IF_ID_valid, 0);
    checkOutput("mid_rst_pc",    IF_ID_pc,    0);
    checkOutput("mid_rst_instr", IF_ID_instr, 0);
    checkOutput("mid_rst_req",   imem_req,    0);
    applyStimulus(0, 0, 0, '0, 0, 1);
    tick();
    checkOutput("in_rst_valid", IF_ID_valid, 0);
    reset = 1'b1;
    #1;
    checkOutput("post_rst_valid", IF_ID_valid, 0);
    checkOutput("post_rst_addr",  imem_addr,   0);
    tick();
    checkOutput("post_rst_pc",    IF_ID_pc,    64'h0);
    checkOutput("post_rst_instr", IF_ID_instr, 32'h8B00_0000);
    checkOutput("post_rst_valid2", IF_ID_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
